// File: rtl/div_rv32m_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : div_rv32m_ctrl_pkg
// Brief  : Shared encodings for the RV32M divide sequencing stage:
//          opcode values, FSM state type, 32-bit boundary constants and
//          small opcode decode helpers.
// Rev    : 1.0  initial release
// ============================================================================
package div_rv32m_ctrl_pkg;

  // req_op encodings (bit0 = unsigned, bit1 = remainder)
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [31:0] INT32_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_rv32m_ctrl_neg32_cond.sv
`default_nettype none
// ============================================================================
// Module : neg32_cond
// Brief  : Conditional 32-bit two's-complement negate (combinational).
// Ports  : i_neg  - 1 = output -i_din (mod 2^32), 0 = pass through
//          i_din  - 32-bit operand
//          o_dout - 32-bit result
// Rev    : 1.0  initial release
// ============================================================================
module neg32_cond (
  input  logic        i_neg,
  input  logic [31:0] i_din,
  output logic [31:0] o_dout
);

  assign o_dout = i_neg ? (~i_din + 32'd1) : i_din;

endmodule
`default_nettype wire

// File: rtl/div_rv32m_ctrl.sv
`default_nettype none
// ============================================================================
// Module : div_rv32m_ctrl
// Brief  : RV32M DIV/DIVU/REM/REMU sequencing and sign handling around an
//          iterative unsigned 32-bit divider core. Handles divide-by-zero and
//          signed overflow locally, otherwise starts the core on operand
//          magnitudes and sign-corrects the returned quotient/remainder.
// Ports  : clk, rst (async, active-low)
//          req_*      - request channel (valid/ready, op, a, b, tag)
//          resp_*     - response channel (valid/ready, data, tag)
//          core_*     - unsigned divider core handshake and operands/results
//          busy       - high whenever the FSM is not idle
// Config : DIV_RESULT_CACHE_EN - keep the last core-computed result and reuse
//          it for a matching request (e.g. REM right after DIV).
// Rev    : 1.0  initial release
// ============================================================================
module div_rv32m_ctrl
  import div_rv32m_ctrl_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             core_start,
  output logic [31:0]      core_dived,
  output logic [31:0]      core_divor,
  input  logic             core_done,
  input  logic [31:0]      core_quoti,
  input  logic [31:0]      core_remai,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      q_q, q_d, r_q, r_d;
  logic [31:0]      dived_q, dived_d, divor_q, divor_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic        w_sgn, w_b_zero, w_ovf, w_start;
  logic        w_hit;
  logic [31:0] w_hit_q, w_hit_r;
  logic [31:0] w_a_mag, w_b_mag, w_q_fix, w_r_fix;

  assign w_sgn    = op_is_signed(op_q);
  assign w_b_zero = (b_q == 32'd0);
  assign w_ovf    = w_sgn && (a_q == INT32_MIN) && (b_q == ALL_ONES);

  // Operand magnitudes for the unsigned core
  neg32_cond u_neg_a (.i_neg(w_sgn & a_q[31]), .i_din(a_q), .o_dout(w_a_mag));
  neg32_cond u_neg_b (.i_neg(w_sgn & b_q[31]), .i_din(b_q), .o_dout(w_b_mag));

  // Quotient is negative when operand signs differ; remainder follows dividend
  neg32_cond u_fix_q (.i_neg(w_sgn & (a_q[31] ^ b_q[31])), .i_din(q_q), .o_dout(w_q_fix));
  neg32_cond u_fix_r (.i_neg(w_sgn & a_q[31]),             .i_din(r_q), .o_dout(w_r_fix));

`ifdef DIV_RESULT_CACHE_EN
  logic [31:0] ca_q, ca_d, cb_q, cb_d, cq_q, cq_d, cr_q, cr_d;
  logic        csgn_q, csgn_d, cvld_q, cvld_d;

  // Raw operands plus signed-ness fully identify the final q/r pair
  assign w_hit   = cvld_q && (ca_q == a_q) && (cb_q == b_q) && (csgn_q == w_sgn);
  assign w_hit_q = cq_q;
  assign w_hit_r = cr_q;

  always_comb begin
    ca_d   = ca_q;
    cb_d   = cb_q;
    cq_d   = cq_q;
    cr_d   = cr_q;
    csgn_d = csgn_q;
    cvld_d = cvld_q;
    if (state_q == ST_FIX) begin
      ca_d   = a_q;
      cb_d   = b_q;
      cq_d   = w_q_fix;
      cr_d   = w_r_fix;
      csgn_d = w_sgn;
      cvld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ca_q   <= '0;
      cb_q   <= '0;
      cq_q   <= '0;
      cr_q   <= '0;
      csgn_q <= 1'b0;
      cvld_q <= 1'b0;
    end else begin
      ca_q   <= ca_d;
      cb_q   <= cb_d;
      cq_q   <= cq_d;
      cr_q   <= cr_d;
      csgn_q <= csgn_d;
      cvld_q <= cvld_d;
    end
  end
`else
  assign w_hit   = 1'b0;
  assign w_hit_q = '0;
  assign w_hit_r = '0;
`endif

  // Special cases take priority, so they never hit the cache
  assign w_start = (state_q == ST_CHK) && !w_b_zero && !w_ovf && !w_hit;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    q_d     = q_q;
    r_d     = r_q;
    dived_d = dived_q;
    divor_d = divor_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          tag_d   = req_tag;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (w_b_zero) begin
          q_d     = ALL_ONES;
          r_d     = a_q;
          state_d = ST_RESP;
        end else if (w_ovf) begin
          q_d     = INT32_MIN;
          r_d     = '0;
          state_d = ST_RESP;
        end else if (w_hit) begin
          q_d     = w_hit_q;
          r_d     = w_hit_r;
          state_d = ST_RESP;
        end else begin
          dived_d = w_a_mag;
          divor_d = w_b_mag;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          q_d     = core_quoti;
          r_d     = core_remai;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        q_d     = w_q_fix;
        r_d     = w_r_fix;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dived_q <= '0;
      divor_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dived_q <= dived_d;
      divor_q <= divor_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_data  = resp_valid ? (op_is_rem(op_q) ? r_q : q_q) : 32'd0;
  assign resp_tag   = tag_q;
  assign core_start = w_start;
  // Magnitudes go out combinationally in the start cycle, then from the
  // registered copy so they stay stable until the core finishes.
  assign core_dived = w_start ? w_a_mag : dived_q;
  assign core_divor = w_start ? w_b_mag : divor_q;

endmodule
`default_nettype wire

// File: tb/tb_div_rv32m_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_div_rv32m_ctrl
// Brief  : Self-checking bench for div_rv32m_ctrl with a behavioural unsigned
//          divider core model and an RV32M reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_div_rv32m_ctrl;
  import div_rv32m_ctrl_pkg::*;

  localparam int TAG_W = 4;
`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             core_start;
  logic [31:0]      core_dived;
  logic [31:0]      core_divor;
  logic             core_done = 1'b0;
  logic [31:0]      core_quoti = '0;
  logic [31:0]      core_remai = '0;
  logic             busy;

  always #5 clk = ~clk;

  div_rv32m_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .core_start(core_start), .core_dived(core_dived), .core_divor(core_divor),
    .core_done(core_done), .core_quoti(core_quoti), .core_remai(core_remai),
    .busy(busy)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- unsigned divider core model ----------------
  int          core_lat = 4;
  int          start_cnt = 0;
  int          pend = 0;
  logic [31:0] hold_dived = '0, hold_divor = '0;
  logic [31:0] exp_dived = '0, exp_divor = '0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (pend > 0) begin
      if (busy) begin
        chk("core_dived_stable", core_dived, hold_dived);
        chk("core_divor_stable", core_divor, hold_divor);
      end
      pend--;
      if (pend == 0) begin
        core_done  = 1'b1;
        core_quoti = (hold_divor == 0) ? 32'hFFFFFFFF : hold_dived / hold_divor;
        core_remai = (hold_divor == 0) ? hold_dived   : hold_dived % hold_divor;
      end
    end
    if (core_start) begin
      start_cnt++;
      chk("core_dived", core_dived, exp_dived);
      chk("core_divor", core_divor, exp_divor);
      hold_dived = core_dived;
      hold_divor = core_divor;
      pend       = core_lat;
    end
  end

  // ---------------- RV32M reference model ----------------
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    bit is_rem, sgn;
    is_rem = op[1];
    sgn    = !op[0];
    sa     = a;
    sb     = b;
    if (b == 0) return is_rem ? a : 32'hFFFFFFFF;
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return is_rem ? 32'd0 : 32'h80000000;
    if (sgn) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    return is_rem ? a % b : a / b;
  endfunction

  // last core-computed operands, for predicting cache hits
  logic [31:0] mc_a = '0, mc_b = '0;
  bit          mc_sgn = 1'b0, mc_vld = 1'b0;

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic [31:0] exp_data, input int lat_core, input int hold);
    bit sgn, special, hit, exp_start;
    int exp_lat, lat, s0, w;
    sgn       = !op[0];
    special   = (b == 0) || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF);
    hit       = CACHE_EN && !special && mc_vld && mc_a == a && mc_b == b && mc_sgn == sgn;
    exp_start = !special && !hit;
    exp_lat   = exp_start ? lat_core + 3 : 2;
    exp_dived = (sgn && a[31]) ? -a : a;
    exp_divor = (sgn && b[31]) ? -b : b;
    core_lat  = lat_core;
    s0        = start_cnt;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(negedge clk);
    // garbage on the request port while busy must be ignored
    req_a = $urandom; req_b = $urandom; req_op = 2'($urandom); req_tag = TAG_W'($urandom);
    lat = 1;
    while (!resp_valid && lat < 200) begin @(negedge clk); lat++; end
    req_valid = 1'b0;
    chk({name, "_latency"}, lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      chk({name, "_hold_data"}, resp_data, exp_data);
      chk({name, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk({name, "_data"}, resp_data, exp_data);
    chk({name, "_tag"}, {28'd0, resp_tag}, {28'd0, tag});
    chk({name, "_valid"}, {31'd0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({name, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
    chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_starts"}, start_cnt - s0, {31'd0, exp_start});
    if (exp_start && CACHE_EN) begin
      mc_a = a; mc_b = b; mc_sgn = sgn; mc_vld = 1'b1;
    end
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
    int               hold;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          4'd3,  32'd14,         0};
    tbl[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,          4'd4,  32'd2,          1};
    tbl[2]  = '{DIV_OP_DIV,  32'hFFFFFFF9,   32'd2,          4'd5,  32'hFFFFFFFD,   0};
    tbl[3]  = '{DIV_OP_REM,  32'hFFFFFFF9,   32'd2,          4'd6,  32'hFFFFFFFF,   0};
    tbl[4]  = '{DIV_OP_DIV,  32'd5,          32'd0,          4'd7,  32'hFFFFFFFF,   0};
    tbl[5]  = '{DIV_OP_REM,  32'd5,          32'd0,          4'd8,  32'd5,          0};
    tbl[6]  = '{DIV_OP_DIV,  32'h80000000,   32'hFFFFFFFF,   4'd9,  32'h80000000,   0};
    tbl[7]  = '{DIV_OP_REM,  32'h80000000,   32'hFFFFFFFF,   4'd10, 32'd0,          0};
    tbl[8]  = '{DIV_OP_DIVU, 32'd1000,       32'd10,         4'd11, 32'd100,        10};
    tbl[9]  = '{DIV_OP_DIV,  32'd100,        32'hFFFFFFF9,   4'd12, 32'hFFFFFFF2,   0};
    tbl[10] = '{DIV_OP_REM,  32'd100,        32'hFFFFFFF9,   4'd13, 32'd2,          0};
    tbl[11] = '{DIV_OP_DIVU, 32'd100,        32'hFFFFFFF9,   4'd14, 32'd0,          0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", {28'd0, resp_tag}, 32'd0);
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    chk("rst_core_dived", core_dived, 32'd0);
    chk("rst_core_divor", core_divor, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

    // directed table
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag,
             tbl[i].exp, 1 + (i % 5), tbl[i].hold);

    // reset while the core is running
    exp_dived = 32'd1000; exp_divor = 32'd3; core_lat = 12;
    req_valid = 1'b1; req_op = DIV_OP_DIVU; req_a = 32'd1000; req_b = 32'd3; req_tag = 4'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("run_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_resp_data", resp_data, 32'd0);
    chk("midrst_resp_tag", {28'd0, resp_tag}, 32'd0);
    chk("midrst_core_start", {31'd0, core_start}, 32'd0);
    chk("midrst_core_dived", core_dived, 32'd0);
    chk("midrst_core_divor", core_divor, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mc_vld = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("late_done_busy", {31'd0, busy}, 32'd0);
      chk("late_done_resp_valid", {31'd0, resp_valid}, 32'd0);
    end
    run_op("post_rst_divu", DIV_OP_DIVU, 32'd9, 32'd3, 4'd2, 32'd3, 3, 0);

    // randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom);
      if ($urandom_range(0, 3) == 0 && n > 0) begin
        a = req_a; b = req_b;
        a = mc_a;  b = mc_b;
      end else begin
        case ($urandom_range(0, 5))
          0:       a = 32'h80000000;
          1:       a = $urandom_range(0, 200);
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 6))
          0:       b = 32'd0;
          1:       b = 32'hFFFFFFFF;
          2:       b = $urandom_range(1, 20);
          default: b = $urandom;
        endcase
      end
      run_op($sformatf("rnd%0d", n), op, a, b, TAG_W'($urandom), ref_res(op, a, b),
             $urandom_range(1, 6), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_rv32m_ctrl.md
Name: div_rv32m_ctrl

Overview:
- Sequencing and sign-handling stage wrapped around the iterative unsigned 32-bit divider core.
- Accepts RV32M DIV/DIVU/REM/REMU requests over valid/ready and converts signed operands to magnitudes.
- Resolves divide-by-zero and signed overflow locally, starts the core, waits for it, and sign-corrects the result.
- Returns the result over a valid/ready response port to the execute/writeback stage.

Parameters:
- TAG_W, 4, width of the request tag carried through to the response (e.g. rd index / ROB slot).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_a  in  32  dividend
- req_b  in  32  divisor
- req_tag  in  TAG_W  request tag
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  quotient or remainder per op
- resp_tag  out  TAG_W  tag of the accepted request
- core_start  out  1  one-cycle start pulse to unsigned core
- core_dived  out  32  unsigned dividend magnitude, stable from start until done
- core_divor  out  32  unsigned divisor magnitude, stable from start until done
- core_done  in  1  one-cycle pulse, core results valid
- core_quoti  in  32  unsigned quotient
- core_remai  in  32  unsigned remainder
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; resp_valid=0, resp_data=0, resp_tag=0, core_start=0, core_dived=0, core_divor=0, busy=0. req_ready=1 after reset release.
- FSM states: IDLE, CHK, RUN, FIX, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch op, a, b, tag; go to CHK.
- CHK, one cycle, special cases:
  - b==0: q=0xFFFFFFFF, r=a; go to RESP.
  - Signed op with a==0x80000000 and b==0xFFFFFFFF: q=0x80000000, r=0; go to RESP.
  - Otherwise: core_dived=|a|, core_divor=|b| (two's-complement negate when signed and bit31 set; unsigned ops pass through); pulse core_start for this one cycle; go to RUN.
- RUN: hold core operands; wait for core_done. On core_done, latch core_quoti/core_remai; go to FIX.
- FIX, one cycle, signed ops only:
  - Negate q iff a[31]^b[31].
  - Negate r iff a[31].
  - Unsigned ops pass through unchanged.
  - Go to RESP.
- RESP: resp_valid=1. resp_data = q for DIV/DIVU, r for REM/REMU. resp_tag = latched tag. Data and tag held stable until resp_ready. On resp_valid&resp_ready, go to IDLE.
- Throughput: one operation in flight; the next request is accepted the cycle after a response handshake.
- Latency, accept to resp_valid: 2 cycles for special cases; core latency + 3 otherwise.
- core_done outside RUN is ignored.
- req_* changes while not in IDLE are ignored.
- Reset mid-operation: immediate return to IDLE, outputs to reset values. A core pulse after reset release is ignored.
- All arithmetic mod 2^32. No exceptions raised.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- Defined:
  - Holds the last core-computed {a, b, signed-ness, final q, final r, valid}.
  - In CHK, a non-special request with equal a, b and signed-ness hits the cache: go straight to RESP with cached q/r and no core_start. Latency 2.
  - Typical use: DIV followed by REM on the same operands.
  - Cache is updated in FIX. Valid is cleared by reset. Special cases neither hit nor update the cache.
- Undefined: no cache storage; every non-special request runs the core.

Decomposition:
- Shared package/header:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU.
  - FSM state encodings.
  - constants INT32_MIN=0x80000000, ALL_ONES=0xFFFFFFFF.
- Sub-module neg32_cond (conditional two's-complement negate, 32-bit, combinational). Used for operand magnitude and result correction.

Test Plan:
- DIVU a=100, b=7 -> core sees 100/7, core_start one cycle; resp_data=14. REMU same operands -> 2. Tags echoed.
- DIV a=-7 (0xFFFFFFF9), b=2 -> core sees 7/2; resp_data=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1).
- DIV a=5, b=0 -> no core_start, resp 2 cycles after accept = 0xFFFFFFFF. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0.
- resp_ready held low 10 cycles -> resp_valid/data/tag stable, req_ready=0; release -> handshake, IDLE, next request accepted the following cycle.
- Deassert rst while in RUN -> all outputs zero at once; late core_done ignored; a fresh DIVU 9/3 returns 3.
- DIV_RESULT_CACHE_EN: DIV 100/-7 (resp 0xFFFFFFF2), then REM 100/-7 -> no core_start, resp_data=2 two cycles after accept. DIVU 100/0xFFFFFFF9 afterwards -> misses (signed-ness differs), core runs.
